hazard_unit_mc: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage MIPS core: forwarding selects, load-use and branch stalls, data-memory-miss freeze, and a registered multi-cycle multiplier tracker with watchdog and stall/miss performance counters. Sits beside the datapath. It consumes decode, execute, memory and writeback register tags plus writeback-source codes, and drives the per-stage stall/flush enables and forwarding muxes.

---
 rtl/hazard_unit_mc.sv | 181 ++++++++++++++++++
 tb/tb_hazard_unit_mc.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
// Pipeline hazard controller for the 5-stage MIPS core. It sits beside the
// datapath. It drives the forwarding selects and the per-stage stall/flush
// enables from the register tags and writeback-source codes. It also tracks a
// multi-cycle multiplier with a watchdog, and counts stall and miss cycles.
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   branchD                      nonzero when a branch/jump-compare is in D
//   rsD, rtD, rsE, rtE           source register tags
//   writeregE/M/W, regwriteE/M/W destination tags and their write enables
//   wbsrcE, wbsrcM               writeback-source codes in E and M
//   hitM                         data cache hit for the access in M
//   multstartE, pve              multiplier start in E, product valid
//   perf_clr                     synchronous clear of the perf counters
//   stallF..stallW, flushE       pipeline stage controls
//   forwardAD/BD                 D-stage forward from M
//   forwardAE/BE                 E-stage forward select (10 = M, 01 = W, 00 = RF)
//   mult_busy, mult_timeout      multiplier busy, sticky watchdog flag
//   stall_cnt, miss_cnt          saturating perf counters
module hazard_unit_mc #(
    parameter int                REG_AW       = 5,
    parameter int                WB_W         = 4,
    parameter logic [WB_W-1:0]   LOADE_CODE   = 4'b1111,
    parameter logic [WB_W-1:0]   BRM_CODE     = 4'b1110,
    parameter int                MULT_TIMEOUT = 64,
    parameter int                CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        branchD,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic [WB_W-1:0]   wbsrcE,
    input  logic [WB_W-1:0]   wbsrcM,
    input  logic              hitM,
    input  logic              multstartE,
    input  logic              pve,
    input  logic              perf_clr,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              stallW,
    output logic              flushE,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              mult_busy,
    output logic              mult_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    typedef enum logic {IDLE, BUSY} mult_state_t;

    localparam int              TW         = $clog2(MULT_TIMEOUT);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(MULT_TIMEOUT - 1);

    mult_state_t   state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic          timeout_set;

    logic loaduse, brstall, miss, multstall, missfreeze, missduringmult;
    logic front_stall, back_stall;

    // Register 0 is hardwired, so a zero tag never creates a dependency.
    function automatic logic tag_match(input logic [REG_AW-1:0] a,
                                       input logic [REG_AW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    // Forwarding: the M stage holds the newer value, so it wins over W.
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (regwriteM && tag_match(rsE, writeregM))      forwardAE = 2'b10;
        else if (regwriteW && tag_match(rsE, writeregW)) forwardAE = 2'b01;
        if (regwriteM && tag_match(rtE, writeregM))      forwardBE = 2'b10;
        else if (regwriteW && tag_match(rtE, writeregW)) forwardBE = 2'b01;
        forwardAD = regwriteM && tag_match(rsD, writeregM);
        forwardBD = regwriteM && tag_match(rtD, writeregM);
    end

    // Hazard detection. The multiplier stalls in its start cycle, before
    // BUSY is registered. A miss alongside a start does not freeze the back
    // end by itself. It is caught instead through missduringmult.
    always_comb begin
        loaduse = (wbsrcE == LOADE_CODE) &&
                  (tag_match(rsD, rtE) || tag_match(rtD, rtE));
        brstall = (branchD != 2'b00) &&
                  ((regwriteE && (tag_match(rsD, writeregE) || tag_match(rtD, writeregE))) ||
                   ((wbsrcM == BRM_CODE) &&
                    (tag_match(rsD, writeregM) || tag_match(rtD, writeregM))));
        miss           = !hitM && (wbsrcM[1:0] == 2'b11);
        multstall      = multstartE || ((state == BUSY) && !pve);
        missfreeze     = miss && !multstartE;
        missduringmult = miss && multstall;
        front_stall    = loaduse || brstall || multstall || missfreeze;
        back_stall     = missfreeze || missduringmult;
    end

    // A frozen back end must not also be flushed, so the stall masks the flush.
    always_comb begin
        stallF = front_stall;
        stallD = front_stall;
        stallE = back_stall;
        stallM = back_stall;
        stallW = back_stall;
        flushE = (loaduse || brstall || multstall) && !back_stall;
    end

    assign mult_busy = (state == BUSY);

    // Multiplier tracker next-state logic. A new start reloads the timer even
    // while busy. pve takes precedence over the watchdog, so a product that
    // lands on the last allowed cycle does not raise the timeout.
    always_comb begin
        state_next  = state;
        timer_next  = timer;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (multstartE) begin
                    state_next = BUSY;
                    timer_next = '0;
                end
            end
            BUSY: begin
                if (multstartE) begin
                    timer_next = '0;
                end else if (pve) begin
                    state_next = IDLE;
                end else if (timer == TIMER_LAST) begin
                    state_next  = IDLE;
                    timeout_set = 1'b1;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Multiplier state, timer and sticky watchdog flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            timer        <= '0;
            mult_timeout <= 1'b0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            if (timeout_set) mult_timeout <= 1'b1;
        end
    end

    // Saturating perf counters. A clear overrides a simultaneous increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            miss_cnt  <= '0;
        end else if (perf_clr) begin
            stall_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            if (front_stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
            if (back_stall  && (miss_cnt  != {CNT_W{1'b1}})) miss_cnt  <= miss_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc
// Self-checking bench for hazard_unit_mc. A small watchdog limit and narrow
// counters make the timeout and saturation corners reachable in a few cycles.
// A behavioural model tracks the multiplier as "busy, N cycles since the last
// start". It tracks the counters as plain saturating integers.
module tb_hazard_unit_mc;

    localparam int AW   = 5;
    localparam int WW   = 4;
    localparam int MT   = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    branchD;
    logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic          regwriteE, regwriteM, regwriteW;
    logic [WW-1:0] wbsrcE, wbsrcM;
    logic          hitM, multstartE, pve, perf_clr;
    logic          stallF, stallD, stallE, stallM, stallW, flushE;
    logic          forwardAD, forwardBD;
    logic [1:0]    forwardAE, forwardBE;
    logic          mult_busy, mult_timeout;
    logic [CW-1:0] stall_cnt, miss_cnt;
    logic [13:0]   obs_comb;
    logic [13:0]   exp_comb;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit m_busy;
    int m_cycles;
    bit m_timeout;
    int m_stall_cnt;
    int m_miss_cnt;

    always #5 clk = ~clk;

    hazard_unit_mc #(
        .REG_AW(AW), .WB_W(WW), .LOADE_CODE(4'b1111), .BRM_CODE(4'b1110),
        .MULT_TIMEOUT(MT), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .branchD(branchD),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .wbsrcE(wbsrcE), .wbsrcM(wbsrcM), .hitM(hitM),
        .multstartE(multstartE), .pve(pve), .perf_clr(perf_clr),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .stallW(stallW), .flushE(flushE), .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .mult_busy(mult_busy),
        .mult_timeout(mult_timeout), .stall_cnt(stall_cnt), .miss_cnt(miss_cnt)
    );

    assign obs_comb = {stallF, stallD, stallE, stallM, stallW, flushE,
                       forwardAD, forwardBD, forwardAE, forwardBE, mult_busy, mult_timeout};

    function automatic bit dep(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_e(input logic [AW-1:0] src);
        if (regwriteM && dep(src, writeregM)) return 2'b10;
        if (regwriteW && dep(src, writeregW)) return 2'b01;
        return 2'b00;
    endfunction

    // Expected combinational outputs from the rules and the model state.
    function automatic logic [13:0] model_comb();
        bit lu, bs, miss, ms, front, back, fl;
        lu    = (wbsrcE == 4'b1111) && (dep(rsD, rtE) || dep(rtD, rtE));
        bs    = (branchD != 0) &&
                ((regwriteE && (dep(rsD, writeregE) || dep(rtD, writeregE))) ||
                 (wbsrcM == 4'b1110 && (dep(rsD, writeregM) || dep(rtD, writeregM))));
        miss  = !hitM && (wbsrcM[1:0] == 2'b11);
        ms    = multstartE || (m_busy && !pve);
        back  = (miss && !multstartE) || (miss && ms);
        front = lu || bs || ms || (miss && !multstartE);
        fl    = (lu || bs || ms) && !back;
        return {front, front, back, back, back, fl,
                regwriteM && dep(rsD, writeregM), regwriteM && dep(rtD, writeregM),
                fwd_e(rsE), fwd_e(rtE), m_busy, m_timeout};
    endfunction

    task automatic clear_inputs();
        branchD = 0; rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        wbsrcE = 0; wbsrcM = 0; hitM = 0; multstartE = 0; pve = 0; perf_clr = 0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_cycles = 0; m_timeout = 0; m_stall_cnt = 0; m_miss_cnt = 0;
    endtask

    // Advance one clock edge and update the model with the inputs held over it.
    task automatic tick();
        logic [13:0] e;
        e = model_comb();
        @(posedge clk);
        if (perf_clr) begin
            m_stall_cnt = 0;
            m_miss_cnt  = 0;
        end else begin
            if (e[13] && m_stall_cnt < CMAX) m_stall_cnt++;
            if (e[11] && m_miss_cnt  < CMAX) m_miss_cnt++;
        end
        if (!m_busy) begin
            if (multstartE) begin m_busy = 1; m_cycles = 0; end
        end else begin
            m_cycles++;
            if (multstartE) m_cycles = 0;
            else if (pve) m_busy = 0;
            else if (m_cycles >= MT) begin m_busy = 0; m_timeout = 1; end
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs_comb !== 14'd0) begin failures++;
            $display("[TB] FAIL reset_comb: got %h expected %h", obs_comb, 14'd0); end
        checks++;
        if ({stall_cnt, miss_cnt} !== 8'd0) begin failures++;
            $display("[TB] FAIL reset_cnt: got %h expected %h", {stall_cnt, miss_cnt}, 8'd0); end
        do_reset();
        checks++;
        if (obs_comb !== 14'd0) begin failures++;
            $display("[TB] FAIL idle_zero: got %h expected %h", obs_comb, 14'd0); end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        regwriteM = 1; regwriteW = 1; writeregM = 5; writeregW = 5; rsE = 5; #1;
        checks++;
        if (forwardAE !== 2'b10) begin failures++;
            $display("[TB] FAIL fwd_m_prio: got %b expected %b", forwardAE, 2'b10); end
        regwriteM = 0; #1;
        checks++;
        if (forwardAE !== 2'b01) begin failures++;
            $display("[TB] FAIL fwd_w: got %b expected %b", forwardAE, 2'b01); end
        rsE = 0; writeregW = 0; #1;
        checks++;
        if (forwardAE !== 2'b00) begin failures++;
            $display("[TB] FAIL fwd_r0: got %b expected %b", forwardAE, 2'b00); end
        regwriteM = 1; writeregM = 7; rtD = 7; rtE = 7; #1;
        checks++;
        if ({forwardAD, forwardBD, forwardBE} !== 4'b0110) begin failures++;
            $display("[TB] FAIL fwd_d: got %b expected %b", {forwardAD, forwardBD, forwardBE}, 4'b0110); end
        tick();
    endtask

    task automatic test_loaduse();
        clear_inputs();
        wbsrcE = 4'b1111; rtE = 3; rsD = 3; #1;
        checks++;
        if ({stallF, stallD, flushE, stallE} !== 4'b1110) begin failures++;
            $display("[TB] FAIL loaduse: got %b expected %b", {stallF, stallD, flushE, stallE}, 4'b1110); end
        rtE = 0; rsD = 0; #1;
        checks++;
        if (obs_comb !== 14'd0) begin failures++;
            $display("[TB] FAIL loaduse_r0: got %h expected %h", obs_comb, 14'd0); end
        tick();
    endtask

    task automatic test_miss_loaduse();
        int base;
        clear_inputs();
        wbsrcE = 4'b1111; rtE = 3; rsD = 3; hitM = 0; wbsrcM = 4'b0011;
        base = m_miss_cnt;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({stallF, stallD, stallE, stallM, stallW, flushE} !== 6'b111110) begin failures++;
                $display("[TB] FAIL miss_loaduse: got %b expected %b",
                         {stallF, stallD, stallE, stallM, stallW, flushE}, 6'b111110); end
            tick();
        end
        checks++;
        if (miss_cnt !== CW'(base + 3)) begin failures++;
            $display("[TB] FAIL miss_cnt_inc: got %0d expected %0d", miss_cnt, base + 3); end
    endtask

    task automatic test_multiply();
        clear_inputs();
        perf_clr = 1; tick(); perf_clr = 0;
        for (int c = 1; c <= 7; c++) begin
            multstartE = (c == 1);
            pve = (c == 7);
            #1;
            checks++;
            if ({stallF, flushE, mult_busy} !== {c != 7, c != 7, c != 1}) begin failures++;
                $display("[TB] FAIL mult_cycle%0d: got %b expected %b", c,
                         {stallF, flushE, mult_busy}, {c != 7, c != 7, c != 1}); end
            tick();
        end
        pve = 0; #1;
        checks++;
        if ({mult_busy, stall_cnt} !== {1'b0, 4'd6}) begin failures++;
            $display("[TB] FAIL mult_done: got %h expected %h", {mult_busy, stall_cnt}, {1'b0, 4'd6}); end
    endtask

    task automatic test_watchdog();
        clear_inputs();
        // pve on the last allowed cycle beats the watchdog
        multstartE = 1; tick(); multstartE = 0;
        for (int c = 1; c <= MT; c++) begin
            pve = (c == MT);
            tick();
        end
        pve = 0; #1;
        checks++;
        if ({mult_busy, mult_timeout} !== 2'b00) begin failures++;
            $display("[TB] FAIL wd_pve_prio: got %b expected %b", {mult_busy, mult_timeout}, 2'b00); end
        // pve never arrives
        multstartE = 1; tick(); multstartE = 0;
        for (int c = 1; c <= MT; c++) begin
            #1;
            checks++;
            if ({stallF, mult_busy, mult_timeout} !== 3'b110) begin failures++;
                $display("[TB] FAIL wd_busy%0d: got %b expected %b", c,
                         {stallF, mult_busy, mult_timeout}, 3'b110); end
            tick();
        end
        checks++;
        if ({stallF, mult_busy, mult_timeout} !== 3'b001) begin failures++;
            $display("[TB] FAIL wd_fire: got %b expected %b", {stallF, mult_busy, mult_timeout}, 3'b001); end
        // asynchronous reset mid-BUSY clears busy and the sticky flag at once
        multstartE = 1; tick(); multstartE = 0; tick();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({mult_busy, mult_timeout} !== 2'b00) begin failures++;
            $display("[TB] FAIL wd_async_rst: got %b expected %b", {mult_busy, mult_timeout}, 2'b00); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_counters();
        clear_inputs();
        branchD = 2'b01; regwriteE = 1; writeregE = 4; rsD = 4;
        for (int i = 0; i < CMAX + 3; i++) tick();
        checks++;
        if (stall_cnt !== CW'(CMAX)) begin failures++;
            $display("[TB] FAIL cnt_sat: got %0d expected %0d", stall_cnt, CMAX); end
        perf_clr = 1; tick(); perf_clr = 0;
        checks++;
        if (stall_cnt !== 4'd0) begin failures++;
            $display("[TB] FAIL cnt_clr: got %0d expected %0d", stall_cnt, 0); end
        clear_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            branchD    = 2'($urandom_range(0, 3));
            rsD        = AW'($urandom_range(0, 3));
            rtD        = AW'($urandom_range(0, 3));
            rsE        = AW'($urandom_range(0, 3));
            rtE        = AW'($urandom_range(0, 3));
            writeregE  = AW'($urandom_range(0, 3));
            writeregM  = AW'($urandom_range(0, 3));
            writeregW  = AW'($urandom_range(0, 3));
            regwriteE  = 1'($urandom);
            regwriteM  = 1'($urandom);
            regwriteW  = 1'($urandom);
            wbsrcE     = ($urandom_range(0, 2) == 0) ? 4'b1111 : WW'($urandom);
            wbsrcM     = ($urandom_range(0, 2) == 0) ? 4'b1110 : WW'($urandom);
            hitM       = 1'($urandom);
            multstartE = ($urandom_range(0, 9) == 0);
            pve        = ($urandom_range(0, 5) == 0);
            perf_clr   = ($urandom_range(0, 30) == 0);
            #1;
            exp_comb = model_comb();
            checks++;
            if (obs_comb !== exp_comb) begin failures++;
                $display("[TB] FAIL rand_comb[%0d]: got %h expected %h", i, obs_comb, exp_comb); end
            checks++;
            if ({stall_cnt, miss_cnt} !== {CW'(m_stall_cnt), CW'(m_miss_cnt)}) begin failures++;
                $display("[TB] FAIL rand_cnt[%0d]: got %h expected %h", i,
                         {stall_cnt, miss_cnt}, {CW'(m_stall_cnt), CW'(m_miss_cnt)}); end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_loaduse();
        test_miss_loaduse();
        test_multiply();
        test_watchdog();
        test_counters();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
